register_1: RTL and testbench



---
 rtl/register_1.sv | 14 +
 tb/tb_register_1.sv | 120 ++++++++++++
 2 files changed

// File: rtl/register_1.sv
// register_1: WIDTH-bit storage register with write enable and asynchronous active-low clear.
module register_1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             writeEnable,
    input  logic [WIDTH-1:0] inData,
    output logic [WIDTH-1:0] outData
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) outData <= '0;
        else if (writeEnable) outData <= inData;
endmodule

// File: tb/tb_register_1.sv
// tb_register_1: directed checks of register_1 at WIDTH 1 and WIDTH 32.
module tb_register_1;
    logic        clk = 1'b0;
    logic        reset;
    logic        we1, din1, out1;
    logic        we32;
    logic [31:0] din32, out32;
    int          passed = 0;
    int          total = 0;

    register_1 #(.WIDTH(1)) u1 (
        .clk(clk), .reset(reset), .writeEnable(we1), .inData(din1), .outData(out1)
    );
    register_1 #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .writeEnable(we32), .inData(din32), .outData(out32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic pos;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; we1 = 1'b0; din1 = 1'b1; we32 = 1'b0; din32 = 32'hFFFF_FFFF;
        // reset held low across several edges
        #1;
        chk("rst_t0", {31'b0, out1}, 32'h0);
        chk("rst32_t0", out32, 32'h0);
        for (int i = 0; i < 3; i++) begin
            pos;
            chk("rst_pos", {31'b0, out1}, 32'h0);
            neg;
            chk("rst_neg", {31'b0, out1}, 32'h0);
        end
        chk("rst32", out32, 32'h0);
        // release, write disabled
        reset = 1'b1;
        pos;
        chk("hold_in1", {31'b0, out1}, 32'h0);
        neg;
        din1 = 1'b0;
        pos;
        chk("hold_in0", {31'b0, out1}, 32'h0);
        chk("hold32", out32, 32'h0);
        // load 1: not visible before the edge
        neg;
        we1 = 1'b1; din1 = 1'b1;
        #4;
        chk("load1_pre", {31'b0, out1}, 32'h0);
        pos;
        chk("load1", {31'b0, out1}, 32'h1);
        // load 0 then 1
        neg;
        din1 = 1'b0;
        pos;
        chk("load0", {31'b0, out1}, 32'h0);
        neg;
        din1 = 1'b1;
        pos;
        chk("reload1", {31'b0, out1}, 32'h1);
        // enable gating with inData toggling between edges
        neg;
        we1 = 1'b0; din1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pos;
            chk("gate_pos", {31'b0, out1}, 32'h1);
            #1 din1 = ~din1;
            neg;
            chk("gate_neg", {31'b0, out1}, 32'h1);
        end
        // async clear while clk is high
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_clr", {31'b0, out1}, 32'h0);
        neg;
        we1 = 1'b1; din1 = 1'b1;
        pos;
        chk("rst_dominates", {31'b0, out1}, 32'h0);
        // 32-bit sequence
        neg;
        reset = 1'b1; we1 = 1'b0;
        we32 = 1'b1; din32 = 32'hDEAD_BEEF;
        pos;
        chk("w32_beef", out32, 32'hDEAD_BEEF);
        neg;
        din32 = 32'h0000_0000;
        pos;
        chk("w32_zero", out32, 32'h0);
        neg;
        reset = 1'b0;
        #1;
        chk("w32_rst", out32, 32'h0);
        neg;
        reset = 1'b1; din32 = 32'h1234_5678;
        pos;
        chk("w32_load", out32, 32'h1234_5678);
        neg;
        we32 = 1'b0; din32 = 32'hFFFF_FFFF;
        pos;
        chk("w32_gate", out32, 32'h1234_5678);
        #2 reset = 1'b0;
        #1;
        chk("w32_async", out32, 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
